// File: rtl/sync_ram_dp.sv
// ---------------------------------------------------------------------------
// sync_ram_dp
//   Simple dual-port synchronous RAM with one write port and one registered
//   read port on a single clock. After reset, or on request, a clear sweep
//   writes CLR_VAL to every word. BUSY is high during the sweep, and
//   accesses are ignored while it is high.
//
// Parameters
//   DATA_BIT : data word width
//   ADDR_BIT : address width, depth ROW = 2**ADDR_BIT
//   RD_MODE  : same-address read/write collision, 0 = old data, 1 = DIN
//   CLR_VAL  : value written to every word by the clear sweep
//
// Ports
//   CLK      : clock, rising edge
//   RSTN     : asynchronous active-low reset
//   WEN      : write request
//   WADDR    : write address
//   DIN      : write data
//   REN      : read request
//   RADDR    : read address
//   CLR_REQ  : restart the clear sweep (has priority over WEN/REN)
//   DOUT     : registered read data, held between reads
//   DVALID   : one-cycle strobe, DOUT updated by a read
//   BUSY     : clear sweep in progress
// ---------------------------------------------------------------------------
module sync_ram_dp #(
  parameter int                  DATA_BIT = 8,
  parameter int                  ADDR_BIT = 4,
  parameter int                  RD_MODE  = 0,
  parameter logic [DATA_BIT-1:0] CLR_VAL  = '0
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                WEN,
  input  logic [ADDR_BIT-1:0] WADDR,
  input  logic [DATA_BIT-1:0] DIN,
  input  logic                REN,
  input  logic [ADDR_BIT-1:0] RADDR,
  input  logic                CLR_REQ,
  output logic [DATA_BIT-1:0] DOUT,
  output logic                DVALID,
  output logic                BUSY
);

  localparam int                  ROW       = 1 << ADDR_BIT;
  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(ROW - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_BIT-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_BIT-1:0] dout_q, dout_d;
  logic                dvalid_q, dvalid_d;

  logic [DATA_BIT-1:0] mem [ROW];

  logic                mem_we;
  logic [ADDR_BIT-1:0] mem_waddr;
  logic [DATA_BIT-1:0] mem_wdata;
  logic [DATA_BIT-1:0] rd_word;

  // The read data source. In write-through mode a same-address write
  // bypasses the array so that DOUT sees DIN. Otherwise the array still
  // holds the pre-write word at this point.
  always_comb begin
    rd_word = mem[RADDR];
    if ((RD_MODE == 1) && WEN && (WADDR == RADDR)) begin
      rd_word = DIN;
    end
  end

  // Next-state and array-port logic. The sweep shares the single write
  // port with normal writes, because the two never overlap in time.
  // CLR_REQ takes priority over everything in both states.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = CLR_VAL;

    case (state_q)
      CLEAR: begin
        if (CLR_REQ) begin
          clr_cnt_d = '0;
        end else begin
          mem_we    = 1'b1;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            state_d = READY;
          end
        end
      end
      READY: begin
        if (CLR_REQ) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          if (WEN) begin
            mem_we    = 1'b1;
            mem_waddr = WADDR;
            mem_wdata = DIN;
          end
          if (REN) begin
            dout_d   = rd_word;
            dvalid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Control and output registers. Reset aborts any sweep or read.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
    end
  end

  // Storage has no reset. The sweep is the only way it gets cleared.
  // Gating with RSTN keeps the CLEAR state's sweep write from landing
  // while reset is held.
  always_ff @(posedge CLK) begin
    if (mem_we && RSTN) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign BUSY   = (state_q == CLEAR);

endmodule

// File: doc/sync_ram_dp.md
SYNC_RAM_DP -- requirements
Module: sync_ram_dp

Interface
REQ-001 SHALL have parameter DATA_BIT, default 8, the data word width in bits.
REQ-002 SHALL have parameter ADDR_BIT, default 4, the address width; depth ROW = 2**ADDR_BIT.
REQ-003 SHALL have parameter RD_MODE, default 0, the same-address collision policy: 0 = read-first (old data), 1 = write-through (DIN).
REQ-004 SHALL have parameter CLR_VAL, default 0, the DATA_BIT-wide value written to every word during a clear sweep.
REQ-005 SHALL have port CLK, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port RSTN, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-007 SHALL have port WEN, input, 1 bit, the write request.
REQ-008 SHALL have port WADDR, input, ADDR_BIT bits, the write address.
REQ-009 SHALL have port DIN, input, DATA_BIT bits, the write data.
REQ-010 SHALL have port REN, input, 1 bit, the read request.
REQ-011 SHALL have port RADDR, input, ADDR_BIT bits, the read address.
REQ-012 SHALL have port CLR_REQ, input, 1 bit, a request to restart the clear sweep.
REQ-013 SHALL have port DOUT, output, DATA_BIT bits, the registered read data.
REQ-014 SHALL have port DVALID, output, 1 bit, a one-cycle strobe marking DOUT as updated.
REQ-015 SHALL have port BUSY, output, 1 bit, high while a clear sweep is in progress.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and READY.
REQ-017 SHALL, in CLEAR, write CLR_VAL to address clr_cnt on each edge and increment clr_cnt, a counter of ADDR_BIT bits.
REQ-018 SHALL move from CLEAR to READY on the edge that writes address ROW-1; BUSY SHALL be low from the next cycle.
REQ-019 SHALL hold BUSY high for exactly ROW cycles after reset release, absent CLR_REQ.
REQ-020 SHALL ignore WEN and REN while BUSY=1: no array write, no DVALID.
REQ-021 SHALL, in READY with WEN=1, write DIN to WADDR on the edge.
REQ-022 SHALL, in READY with REN=1, load DOUT from RADDR on the edge and assert DVALID for the following cycle only (read latency 1).
REQ-023 SHALL hold DOUT at its last value when no read is accepted; DVALID SHALL be 0 in that case.
REQ-024 SHALL, for WEN=REN=1 with WADDR==RADDR, load DOUT with the pre-write word when RD_MODE=0 and with DIN when RD_MODE=1; the array always receives DIN.
REQ-025 SHALL support back-to-back reads: REN high for N consecutive cycles gives DVALID high for N consecutive cycles, one cycle later.
REQ-026 SHALL, on CLR_REQ=1 in READY, enter CLEAR with clr_cnt=0 on the next edge; WEN and REN in that cycle are ignored (CLR_REQ has priority).
REQ-027 SHALL, on CLR_REQ=1 in CLEAR, restart the sweep (clr_cnt=0); BUSY stays high.
REQ-028 SHALL still deliver DVALID for a read accepted in the cycle before CLR_REQ.
REQ-029 SHALL leave the array contents undefined until the first sweep completes; the sweep is the only clear mechanism.

Reset
REQ-030 SHALL, while RSTN=0, force state=CLEAR, clr_cnt=0, DOUT=0, DVALID=0, BUSY=1, asynchronously.
REQ-031 SHALL, on RSTN asserted mid-sweep or mid-read, abort the operation immediately; the sweep restarts at address 0 after release.
REQ-032 SHALL leave array contents untouched by reset itself (no reset on memory storage).

Verification (DATA_BIT=8, ADDR_BIT=4, CLR_VAL=8'h00)
REQ-033 SHALL cover: release RSTN -> BUSY=1 for 16 cycles then 0; reading addresses 0..15 returns 8'h00, DVALID one cycle after each REN.
REQ-034 SHALL cover: write 8'hA5 to addr 3, then REN addr 3 -> DOUT=8'hA5 with DVALID=1 exactly one cycle after REN.
REQ-035 SHALL cover: addr 7 holds 8'h11; WEN=REN=1 at addr 7 with DIN=8'h22 -> DOUT=8'h11 (RD_MODE=0) or 8'h22 (RD_MODE=1); a later read returns 8'h22.
REQ-036 SHALL cover: write 8'h5A to addr 9; pulse CLR_REQ with WEN=1, DIN=8'hFF, WADDR=2 -> BUSY=1 for 16 cycles; afterwards addr 9=8'h00 and addr 2=8'h00.
REQ-037 SHALL cover: WEN/REN during BUSY -> no DVALID and no array change; CLR_REQ at sweep cycle 10 -> BUSY lasts 16 more cycles.
REQ-038 SHALL cover: RSTN low for one cycle mid-read -> DOUT=0, DVALID=0 immediately; a fresh 16-cycle sweep follows release.
